// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network router slice: default address
// width, packet field offsets, config table selectors and the router FSM states.
package snn_pkg;

    localparam int DEFAULT_ADDR_W = 12;

    // Packet layout is {origin neuron address, destination address}
    localparam int ORIGIN_MSB = 2*DEFAULT_ADDR_W - 1;
    localparam int ORIGIN_LSB = DEFAULT_ADDR_W;
    localparam int DEST_MSB   = DEFAULT_ADDR_W - 1;
    localparam int DEST_LSB   = 0;

    typedef enum logic [1:0] {
        CFG_NADDR = 2'd0,
        CFG_PTR   = 2'd1,
        CFG_DOWN  = 2'd2,
        CFG_RSVD  = 2'd3
    } cfg_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } route_state_e;

    // Index width for an n-entry table, never narrower than one bit
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_priority_encoder.sv
// Combinational lowest-set-bit finder over the pending spike vector.
module spike_priority_encoder
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS = 10,
    parameter int IDX_W       = idxWidth(NUM_NEURONS)
) (
    input  logic [NUM_NEURONS-1:0] i_pending,
    output logic [IDX_W-1:0]       o_lowIdx,
    output logic                   o_anySet
);

    // Scan from the top down so the last hit wins, leaving the lowest index
    always_comb begin
        o_lowIdx = '0;
        o_anySet = 1'b0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (i_pending[i]) begin
                o_lowIdx = IDX_W'(i);
                o_anySet = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_router.sv
// Spike router: captures per-neuron spikes once per timestep, walks the CSR
// fan-out table for each firing neuron and emits {origin, destination}
// packets over a valid/ready handshake.
// Optional packet counter: define SPIKE_ROUTER_PKT_STATS_EN.
module spike_router
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS = 10,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int MAX_CONN    = 32,
    parameter int PTR_W       = 6
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [NUM_NEURONS-1:0] spikes,
    input  logic                   cfg_we,
    input  logic [1:0]             cfg_sel,
    input  logic [PTR_W-1:0]       cfg_idx,
    input  logic [ADDR_W-1:0]      cfg_data,
    output logic                   cfg_err,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic [2*ADDR_W-1:0]    packet,
    output logic                   busy,
    output logic [15:0]            pkt_count
);

    localparam int IDX_W  = idxWidth(NUM_NEURONS);
    localparam int PIDX_W = idxWidth(NUM_NEURONS + 1);
    localparam int DIDX_W = idxWidth(MAX_CONN);

    // Configuration tables
    logic [ADDR_W-1:0]      r_naddr [NUM_NEURONS];
    logic [PTR_W-1:0]       r_ptr   [NUM_NEURONS+1];
    logic [ADDR_W-1:0]      r_down  [MAX_CONN];
    logic                   r_cfgErr;

    // Spike capture
    logic [NUM_NEURONS-1:0] r_pending;
    logic [NUM_NEURONS-1:0] r_fired;
    logic [NUM_NEURONS-1:0] w_pendingNext;

    // Traversal state
    route_state_e           r_state;
    route_state_e           w_nextState;
    logic [IDX_W-1:0]       r_sel;
    logic [PTR_W-1:0]       r_cur;
    logic [PTR_W-1:0]       r_end;
    logic                   r_valid;
    logic [2*ADDR_W-1:0]    r_packet;

    logic [IDX_W-1:0]       w_lowIdx;
    logic [PIDX_W-1:0]      w_lowNext;
    logic                   w_anySet;
    logic                   w_handshake;
    logic                   w_slotFree;
    logic                   w_rangeDone;
    logic                   w_latch;
    logic                   w_load;
    logic                   w_done;
    logic                   w_idxOk;
    logic                   w_cfgAccept;

    spike_priority_encoder #(
        .NUM_NEURONS (NUM_NEURONS),
        .IDX_W       (IDX_W)
    ) u_prio (
        .i_pending (r_pending),
        .o_lowIdx  (w_lowIdx),
        .o_anySet  (w_anySet)
    );

    assign w_lowNext   = PIDX_W'(w_lowIdx) + PIDX_W'(1);
    assign w_handshake = r_valid & pkt_ready;
    assign w_slotFree  = ~r_valid | w_handshake;
    assign w_rangeDone = (r_cur >= r_end) || (r_end > PTR_W'(MAX_CONN));
    assign busy        = (r_state != ST_IDLE) || (|r_pending);

    // Decide whether the addressed table entry exists for the selected table
    always_comb begin
        w_idxOk = 1'b0;
        case (cfg_sel_e'(cfg_sel))
            CFG_NADDR: w_idxOk = (cfg_idx <  PTR_W'(NUM_NEURONS));
            CFG_PTR:   w_idxOk = (cfg_idx <= PTR_W'(NUM_NEURONS));
            CFG_DOWN:  w_idxOk = (cfg_idx <  PTR_W'(MAX_CONN));
            default:   w_idxOk = 1'b0;
        endcase
    end

    assign w_cfgAccept = cfg_we && !busy && w_idxOk;

    // Table writes are only taken while the router is quiet; rejects pulse cfg_err
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_naddr[i] <= '0;
            end
            for (int i = 0; i < NUM_NEURONS + 1; i++) begin
                r_ptr[i] <= '0;
            end
            for (int i = 0; i < MAX_CONN; i++) begin
                r_down[i] <= '0;
            end
            r_cfgErr <= 1'b0;
        end else begin
            r_cfgErr <= cfg_we && !w_cfgAccept;
            if (w_cfgAccept) begin
                case (cfg_sel_e'(cfg_sel))
                    CFG_NADDR: r_naddr[cfg_idx[IDX_W-1:0]]  <= cfg_data;
                    CFG_PTR:   r_ptr[cfg_idx[PIDX_W-1:0]]   <= cfg_data[PTR_W-1:0];
                    CFG_DOWN:  r_down[cfg_idx[DIDX_W-1:0]]  <= cfg_data;
                    default:   ;
                endcase
            end
        end
    end

    // Retire the finished neuron first, then queue spikes not yet seen this timestep
    always_comb begin
        w_pendingNext = r_pending;
        if (w_done) begin
            w_pendingNext[r_sel] = 1'b0;
        end
        w_pendingNext = w_pendingNext | (spikes & ~r_fired);
    end

    // Pending/fired capture; clear wins over the fired update but not over pending
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_pending <= '0;
            r_fired   <= '0;
        end else begin
            r_pending <= w_pendingNext;
            r_fired   <= clear ? '0 : (r_fired | spikes);
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state: pick the lowest pending neuron, then stream its fan-out
    always_comb begin
        w_nextState = r_state;
        w_latch     = 1'b0;
        w_load      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_anySet) begin
                    w_latch     = 1'b1;
                    w_nextState = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_slotFree) begin
                    if (w_rangeDone) begin
                        w_done      = 1'b1;
                        w_nextState = ST_IDLE;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Traversal bounds and the registered packet slot, held steady under backpressure
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_sel    <= '0;
            r_cur    <= '0;
            r_end    <= '0;
            r_valid  <= 1'b0;
            r_packet <= '0;
        end else begin
            if (w_latch) begin
                r_sel <= w_lowIdx;
                r_cur <= r_ptr[w_lowIdx];
                r_end <= r_ptr[w_lowNext];
            end
            if (w_load) begin
                r_valid  <= 1'b1;
                r_packet <= {r_naddr[r_sel], r_down[r_cur[DIDX_W-1:0]]};
                r_cur    <= r_cur + PTR_W'(1);
            end else if (w_done) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign pkt_valid = r_valid;
    assign packet    = r_packet;
    assign cfg_err   = r_cfgErr;

`ifdef SPIKE_ROUTER_PKT_STATS_EN
    logic [15:0] r_pktCount;

    // Count handshakes this timestep, saturating; a handshake on clear restarts at one
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_pktCount <= '0;
        end else if (clear) begin
            r_pktCount <= w_handshake ? 16'd1 : 16'd0;
        end else if (w_handshake && (r_pktCount != 16'hFFFF)) begin
            r_pktCount <= r_pktCount + 16'd1;
        end
    end

    assign pkt_count = r_pktCount;
`else
    assign pkt_count = 16'd0;
`endif

endmodule

// File: doc/spike_router.md
Name: spike_router

Overview:
- Parametrised successor to the fixed 10-neuron network interface.
- Collects per-neuron spike levels from the potential adders and queues each firing neuron once per timestep.
- Walks a CSR fan-out table (connection pointers plus downstream addresses) and emits one {origin, destination} packet per connection over a valid/ready handshake toward the MAC dispatch.

Parameters:
NUM_NEURONS, 10, neurons served; also number of spike inputs.
ADDR_W, 12, neuron address width.
MAX_CONN, 32, downstream table depth.
PTR_W, 6, pointer width; must satisfy 2^PTR_W > MAX_CONN.

Ports:
CLK  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
clear  in  1  timestep-boundary pulse; clears the per-timestep fired mask.
spikes  in  NUM_NEURONS  spike level per neuron (bit i = neuron i).
cfg_we  in  1  table write strobe.
cfg_sel  in  2  target table: 0 = neuron address, 1 = connection pointer, 2 = downstream address; 3 = reserved, write ignored.
cfg_idx  in  PTR_W  table index.
cfg_data  in  ADDR_W  write data; pointers take the low PTR_W bits.
cfg_err  out  1  one-cycle pulse when a write is rejected.
pkt_valid  out  1  packet valid.
pkt_ready  in  1  consumer ready.
packet  out  2*ADDR_W  {origin neuron address, destination address}.
busy  out  1  high when FSM is not IDLE or pending is non-zero.
pkt_count  out  16  packets sent this timestep; zero unless PKT_STATS_EN.

Behaviour:
- Tables:
  - naddr[NUM_NEURONS]; ptr[NUM_NEURONS+1]; down[MAX_CONN].
  - Neuron i's fan-out is down[ptr[i] .. ptr[i+1]-1].
- Reset: all tables, pending, fired, FSM (IDLE), pkt_valid, packet, cfg_err and pkt_count go to 0.
- Capture, every cycle:
  - pending |= spikes & ~fired.
  - fired |= spikes.
  - A neuron therefore queues at most once per timestep.
  - clear zeroes fired in the same cycle, and clear takes priority over that cycle's fired update. Spikes present on the clear cycle still update pending.
- FSM:
  - IDLE: if pending != 0, select the lowest set index k; latch start = ptr[k], end = ptr[k+1]; go to SEND.
  - SEND:
    - If cur >= end, or end > MAX_CONN, clear pending[k] and return to IDLE; no packet is sent.
    - Otherwise drive pkt_valid = 1 with packet = {naddr[k], down[cur]}.
    - On pkt_valid & pkt_ready: cur++.
    - packet must stay stable while valid and not ready.
- Latency: a spike sampled at edge t is in pending after t; SEL at t+1; first pkt_valid after edge t+2. With ready held high, one packet per cycle.
- Ordering: simultaneous spikes are served in ascending neuron index. A lower index arriving mid-traversal waits until the current neuron finishes.
- clear mid-traversal does not abort the traversal; pending is preserved.
- Config writes are accepted only when busy = 0. Otherwise, or if the index is out of range, or cfg_sel = 3, the write is dropped and cfg_err pulses for one cycle.
- reset mid-traversal: pkt_valid drops on the next edge and everything returns to reset values.

Optional Feature:
- Macro: SPIKE_ROUTER_PKT_STATS_EN.
- Defined:
  - pkt_count increments on each handshake, saturating at 16'hFFFF.
  - It zeroes on clear; if a handshake coincides with clear, the count becomes 1.
- Undefined: pkt_count is tied to 0 and no counter logic exists.

Decomposition:
- Shared package snn_pkg holds:
  - ADDR_W default.
  - Packet field offsets: ORIGIN_MSB/LSB, DEST_MSB/LSB.
  - cfg_sel encodings: CFG_NADDR = 0, CFG_PTR = 1, CFG_DOWN = 2.
- One natural sub-module: spike_priority_encoder. Input is the pending vector; outputs are the lowest set index and an any-set flag. It is combinational and parametrised by NUM_NEURONS.

Test Plan:
- Single fan-out:
  - Setup: naddr[i] = i, ptr = {0,3,5,8,10,12,14,15,17,18,19}, down[0..2] = {3,5,7}, pkt_ready = 1.
  - Stimulus: pulse spikes[0].
  - Expect: packets 0x000003, 0x000005, 0x000007 on consecutive cycles, first one 2 cycles after the spike; then busy = 0.
- Simultaneous spikes:
  - Stimulus: spikes[4] and spikes[1] in the same cycle.
  - Expect: neuron 1's packets (to 4, 6) precede neuron 4's (to 8, 9).
- Backpressure: hold pkt_ready = 0 for 5 cycles during neuron 0's second packet; packet stays 0x000005 with valid high, and no packet is lost or duplicated.
- Empty range and duplicate spikes:
  - Set ptr[3] = ptr[4] and spike neuron 3: no packets, pending clears, busy falls.
  - Hold spikes[0] high for 8 cycles without clear: exactly 3 packets.
  - Assert clear while still high: 3 more packets.
- Config rules: write while busy gives cfg_err = 1 for one cycle and the table is unchanged; reset mid-SEND drops pkt_valid at the next edge.
- With SPIKE_ROUTER_PKT_STATS_EN: after neuron 0 and neuron 1 route, pkt_count = 5; clear sets it to 0.
